iob_bus_watch_monitor: RTL and testbench
========================================

// Module: iob_bus_watch_monitor
// PURPOSE
//  Parametrised simulation/debug monitor for a native iob bus (valid/addr/wdata/wstrb/ready).
//  Generalises single-address memory watch + trap-to-finish logic.
//  Provides NUM_WP masked address watchpoints with R/W modes and saturating hit counters.
//  Adds an idle watchdog and a trap/halt state machine; sits in the sim top beside the uut, tapping the internal data bus.
// PARAMETERS
//  ADDR_W      32  bus address width
//  DATA_W      32  bus data width
//  NUM_WP      4   number of watchpoints (1..16)
//  CNT_W       16  per-watchpoint hit counter width
//  HALT_DELAY  10  cycles between halt trigger and halt_req (0 = next cycle)
//  IDLE_MAX    0   cycles without a bus handshake before timeout (0 = watchdog disabled)
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous active-high reset
//  valid        in   1               monitored bus request valid
//  addr         in   ADDR_W          monitored bus address
//  wdata        in   DATA_W          monitored bus write data
//  wstrb        in   DATA_W/8        byte strobes (nonzero = write, zero = read)
//  ready        in   1               monitored bus ready
//  trap         in   1               CPU trap
//  wp_addr      in   NUM_WP*ADDR_W   watch address, wp i at [i*ADDR_W +: ADDR_W]
//  wp_mask      in   NUM_WP*ADDR_W   compare mask, 1 = bit compared
//  wp_mode      in   NUM_WP*2        00 off, 01 write, 10 read, 11 both
//  wp_halt      in   NUM_WP          hit on wp i triggers halt sequence
//  cnt_clr      in   1               synchronous clear of all hit counters
//  hit          out  NUM_WP          one-cycle hit pulse per watchpoint
//  hit_cnt      out  NUM_WP*CNT_W    saturating hit counters
//  last_addr    out  ADDR_W          addr of most recent hitting transaction
//  last_wdata   out  DATA_W          wdata of most recent hitting transaction (0 for reads)
//  timeout      out  1               sticky idle-watchdog flag
//  halt_req     out  1               sticky request to end simulation
//  state        out  2               FSM state: 0 RUN, 1 DRAIN, 2 HALT
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, FSM RUN, idle counter 0.
//  Handshake: transaction accepted in the cycle valid && ready; valid without ready is not counted.
//   Write = |wstrb; read = ~|wstrb.
//  Match i: ((addr ^ wp_addr[i]) & wp_mask[i]) == 0, and mode bit allows the access type.
//  hit[i]: registered, asserted exactly 1 cycle after the handshake cycle, for 1 cycle.
//  hit_cnt[i]: +1 on each match; holds at 2^CNT_W-1 (no wrap).
//   cnt_clr alone zeroes all counters.
//   cnt_clr and match in the same cycle: the counter becomes 1.
//  last_addr/last_wdata: updated on any match, same cycle as hit; unchanged otherwise.
//   Multiple simultaneous matches share one transaction, so values are identical.
//  Idle watchdog (IDLE_MAX>0):
//   - counter clears on every handshake and increments otherwise;
//   - when it reaches IDLE_MAX, timeout=1 (sticky until rst) and the halt trigger fires.
//  Halt trigger = trap | timeout_event | |(match & wp_halt).
//  FSM:
//   - RUN -> DRAIN on trigger (HALT_DELAY>0), loading delay counter = HALT_DELAY-1.
//   - RUN -> HALT on trigger directly if HALT_DELAY==0.
//   - DRAIN: decrements each cycle; -> HALT when counter==0.
//   - DRAIN: further triggers and trap deassertion are ignored.
//   - HALT: halt_req=1, terminal until rst.
//  In DRAIN/HALT, monitoring continues: hits and counters keep updating.
//  rst mid-sequence returns to RUN with all state cleared in the same cycle.
// TESTING
//  1. wp0 addr=0x90D mask=all-ones mode=01; write 0x90D data 0xCAFE -> hit[0] one cycle later, cnt0=1, last_wdata=0xCAFE.
//  2. wp1 mask=0xFFFFFFF0 mode=10; reads 0x100..0x10F, write 0x104 -> cnt1=16, no hit on the write.
//  3. CNT_W=4, 20 matching writes -> cnt saturates at 15; cnt_clr together with a match -> cnt=1.
//  4. trap pulse 1 cycle, HALT_DELAY=10 -> state DRAIN for 10 cycles, then halt_req=1 and held.
//  5. IDLE_MAX=50, no handshakes -> timeout=1 at cycle 50 after last handshake; valid held without ready does not clear it.
//  6. rst asserted during DRAIN -> next cycle state=RUN, halt_req=0, all counters 0.

Source files
------------

// File: rtl/iob_bus_watch_monitor.sv
// Bus watch monitor for a native iob bus: masked address watchpoints with hit
// counters, an idle watchdog, and a trap/halt sequencer for ending simulation.
module iob_bus_watch_monitor #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_WP     = 4,
  parameter int CNT_W      = 16,
  parameter int HALT_DELAY = 10,
  parameter int IDLE_MAX   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     ready,
  input  logic                     trap,
  input  logic [NUM_WP*ADDR_W-1:0] wp_addr,
  input  logic [NUM_WP*ADDR_W-1:0] wp_mask,
  input  logic [NUM_WP*2-1:0]      wp_mode,
  input  logic [NUM_WP-1:0]        wp_halt,
  input  logic                     cnt_clr,
  output logic [NUM_WP-1:0]        hit,
  output logic [NUM_WP*CNT_W-1:0]  hit_cnt,
  output logic [ADDR_W-1:0]        last_addr,
  output logic [DATA_W-1:0]        last_wdata,
  output logic                     timeout,
  output logic                     halt_req,
  output logic [1:0]               state
);

  // state | meaning
  // RUN   | normal monitoring, waiting for a halt trigger
  // DRAIN | trigger seen, counting down HALT_DELAY cycles
  // HALT  | halt_req asserted, terminal until rst
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int DLY_W = (HALT_DELAY > 1) ? $clog2(HALT_DELAY) : 1;

  logic              hs;
  logic              is_wr;
  logic [NUM_WP-1:0] match;
  logic              timeout_event;
  logic              trigger;
  state_t            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;

  always_comb begin
    hs    = valid & ready;
    is_wr = |wstrb;
    match = '0;
    for (int i = 0; i < NUM_WP; i++) begin
      match[i] = hs
        && ~|((addr ^ wp_addr[i*ADDR_W +: ADDR_W]) & wp_mask[i*ADDR_W +: ADDR_W])
        && (is_wr ? wp_mode[2*i] : wp_mode[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit        <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      hit <= match;
      if (|match) begin
        last_addr  <= addr;
        last_wdata <= is_wr ? wdata : '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_WP; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // A clear that coincides with a match still counts that match.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= match[g] ? CNT_W'(1) : '0;
      end else if (match[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end

  if (IDLE_MAX > 0) begin : g_wd
    localparam int IDLE_W = $clog2(IDLE_MAX + 1);
    logic [IDLE_W-1:0] idle_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        idle_q <= '0;
      end else if (hs) begin
        idle_q <= '0;
      end else if (idle_q != IDLE_W'(IDLE_MAX)) begin
        idle_q <= idle_q + 1'b1;
      end
    end

    // Fires on the cycle the idle count reaches IDLE_MAX, once per reset.
    assign timeout_event = !hs && !timeout && (idle_q == IDLE_W'(IDLE_MAX - 1));
  end else begin : g_no_wd
    assign timeout_event = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (timeout_event) begin
      timeout <= 1'b1;
    end
  end

  assign trigger = trap | timeout_event | (|(match & wp_halt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      ST_RUN: begin
        if (trigger) begin
          if (HALT_DELAY == 0) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_DRAIN;
            dly_d   = DLY_W'(HALT_DELAY - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (dly_q == '0) begin
          state_d = ST_HALT;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign halt_req = (state_q == ST_HALT);
  assign state    = state_q;

endmodule

// File: tb/tb_iob_bus_watch_monitor.sv
// Self-checking bench for iob_bus_watch_monitor: cycle-indexed behavioural model,
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_iob_bus_watch_monitor;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NWP = 4;
  localparam int CW  = 5;
  localparam int HD  = 10;
  localparam int IM  = 50;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, valid, ready, trap, cnt_clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic [NWP*AW-1:0] wp_addr, wp_mask;
  logic [NWP*2-1:0] wp_mode;
  logic [NWP-1:0] wp_halt;
  logic [NWP-1:0] hit;
  logic [NWP*CW-1:0] hit_cnt;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic timeout, halt_req;
  logic [1:0] state;

  logic [AW-1:0] wpa [NWP];
  logic [AW-1:0] wpm [NWP];
  logic [1:0]    wpmode [NWP];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    wp_addr = '0;
    wp_mask = '0;
    wp_mode = '0;
    for (int i = 0; i < NWP; i++) begin
      wp_addr[i*AW +: AW] = wpa[i];
      wp_mask[i*AW +: AW] = wpm[i];
      wp_mode[2*i +: 2]   = wpmode[i];
    end
  end

  iob_bus_watch_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_WP(NWP), .CNT_W(CW),
    .HALT_DELAY(HD), .IDLE_MAX(IM)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .ready(ready), .trap(trap), .wp_addr(wp_addr),
    .wp_mask(wp_mask), .wp_mode(wp_mode), .wp_halt(wp_halt),
    .cnt_clr(cnt_clr), .hit(hit), .hit_cnt(hit_cnt), .last_addr(last_addr),
    .last_wdata(last_wdata), .timeout(timeout), .halt_req(halt_req),
    .state(state)
  );

  // Model: everything is expressed in terms of the edge index cyc.
  int cyc = 0;
  bit model_ok = 0;
  int last_hs = 0;
  int halt_edge = 0;
  int m_state = 0;
  int m_cnt [NWP];
  logic [NWP-1:0] m_hit;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  bit m_timeout;

  always @(posedge clk) begin
    bit hs, wr, trig;
    logic [NWP-1:0] mt;
    cyc++;
    if (rst) begin
      model_ok = 1;
      last_hs = cyc;
      m_state = 0;
      m_hit = '0;
      m_last_addr = '0;
      m_last_wdata = '0;
      m_timeout = 0;
      for (int i = 0; i < NWP; i++) m_cnt[i] = 0;
    end else begin
      hs = valid && ready;
      wr = (wstrb != 0);
      mt = '0;
      for (int i = 0; i < NWP; i++)
        if (hs && (((addr ^ wpa[i]) & wpm[i]) == 0) && (wr ? wpmode[i][0] : wpmode[i][1]))
          mt[i] = 1'b1;
      trig = trap || ((mt & wp_halt) != 0);
      if (hs) last_hs = cyc;
      else if ((cyc - last_hs) >= IM && !m_timeout) begin
        m_timeout = 1;
        trig = 1;
      end
      if (m_state == 1 && cyc == halt_edge) m_state = 2;
      else if (m_state == 0 && trig) begin
        if (HD == 0) m_state = 2;
        else begin
          m_state = 1;
          halt_edge = cyc + HD;
        end
      end
      m_hit = mt;
      for (int i = 0; i < NWP; i++) begin
        if (cnt_clr) m_cnt[i] = mt[i] ? 1 : 0;
        else if (mt[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
      if (mt != 0) begin
        m_last_addr = addr;
        m_last_wdata = wr ? wdata : '0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      logic [NWP*CW-1:0] ev;
      ev = '0;
      for (int i = 0; i < NWP; i++) ev[i*CW +: CW] = CW'(m_cnt[i]);
      chk("hit", 64'(hit), 64'(m_hit));
      chk("hit_cnt", 64'(hit_cnt), 64'(ev));
      chk("last_addr", 64'(last_addr), 64'(m_last_addr));
      chk("last_wdata", 64'(last_wdata), 64'(m_last_wdata));
      chk("timeout", 64'(timeout), 64'(m_timeout));
      chk("halt_req", 64'(halt_req), 64'(m_state == 2));
      chk("state", 64'(state), 64'(m_state));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    valid = 0; ready = 0; addr = '0; wdata = '0; wstrb = '0; trap = 0; cnt_clr = 0;
  endtask

  task automatic bus(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    valid = 1; ready = 1; addr = a; wdata = d; wstrb = s;
  endtask

  task automatic do_reset();
    rst = 1; idle_bus(); step(); rst = 0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return hit_cnt[i*CW +: CW];
  endfunction

  initial begin
    rst = 1;
    idle_bus();
    wpa[0] = 32'h90D;  wpm[0] = 32'hFFFF_FFFF; wpmode[0] = 2'b01;
    wpa[1] = 32'h100;  wpm[1] = 32'hFFFF_FFF0; wpmode[1] = 2'b10;
    wpa[2] = 32'h2000; wpm[2] = 32'hFFFF_FF00; wpmode[2] = 2'b11;
    wpa[3] = 32'h3000; wpm[3] = 32'hFFFF_FFFF; wpmode[3] = 2'b01;
    wp_halt = 4'b1000;
    step(); step();
    rst = 0;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_cnt", 64'(hit_cnt), 64'd0);

    // single write hit
    bus(32'h90D, 32'hCAFE, 4'hF); step(); idle_bus();
    chk("t1_hit", 64'(hit), 64'h1);
    chk("t1_cnt0", 64'(cnt_of(0)), 64'd1);
    chk("t1_wdata", 64'(last_wdata), 64'hCAFE);
    chk("t1_addr", 64'(last_addr), 64'h90D);
    step();
    chk("t1_pulse", 64'(hit), 64'h0);

    // masked read range, write filtered out by mode
    for (int i = 0; i < 16; i++) begin
      bus(32'h100 + i, 32'h0, 4'h0); step();
    end
    chk("t2_last_rdata", 64'(last_wdata), 64'd0);
    bus(32'h104, 32'h1234, 4'hF); step(); idle_bus();
    chk("t2_no_wr_hit", 64'(hit[1]), 64'd0);
    step();
    chk("t2_cnt1", 64'(cnt_of(1)), 64'd16);

    // valid without ready is not a transaction
    valid = 1; ready = 0; addr = 32'h90D; wstrb = 4'hF; step(); idle_bus();
    chk("t3_noready", 64'(hit), 64'd0);

    // saturation and clear
    for (int i = 0; i < 40; i++) begin
      bus(32'h90D, 32'(i), 4'h3); step();
    end
    idle_bus(); step();
    chk("t3_sat", 64'(cnt_of(0)), 64'(CMAX));
    bus(32'h90D, 32'h55, 4'h1); cnt_clr = 1; step(); idle_bus();
    chk("t3_clr_match", 64'(cnt_of(0)), 64'd1);
    cnt_clr = 1; step(); idle_bus();
    chk("t3_clr_only", 64'(cnt_of(0)), 64'd0);

    // trap drain sequence
    do_reset();
    trap = 1; step(); trap = 0;
    for (int k = 0; k < HD; k++) begin
      chk("t4_drain", 64'(state), 64'd1);
      step();
    end
    chk("t4_halt_state", 64'(state), 64'd2);
    chk("t4_halt_req", 64'(halt_req), 64'd1);
    repeat (5) step();
    chk("t4_halt_held", 64'(halt_req), 64'd1);

    // reset during drain
    do_reset();
    bus(32'h2010, 32'hBEEF, 4'h0); step();
    bus(32'h90D, 32'hBEEF, 4'hF); step(); idle_bus();
    trap = 1; step(); trap = 0;
    step(); step();
    chk("t6_in_drain", 64'(state), 64'd1);
    rst = 1; step(); rst = 0;
    chk("t6_state", 64'(state), 64'd0);
    chk("t6_halt_req", 64'(halt_req), 64'd0);
    chk("t6_cnt", 64'(hit_cnt), 64'd0);

    // idle watchdog
    do_reset();
    bus(32'h5000, 32'h1, 4'hF); step();
    valid = 1; ready = 0;
    repeat (IM - 1) step();
    chk("t5_before", 64'(timeout), 64'd0);
    step();
    chk("t5_timeout", 64'(timeout), 64'd1);
    chk("t5_drain", 64'(state), 64'd1);
    idle_bus();

    // random traffic
    do_reset();
    for (int i = 0; i < NWP; i++) wpmode[i] = 2'($urandom_range(0, 3));
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, NWP - 1);
      valid = ($urandom_range(0, 1) == 1);
      ready = ($urandom_range(0, 1) == 1);
      addr = ($urandom_range(0, 3) == 0) ? $urandom : (wpa[r] ^ ($urandom & 32'h1F));
      wdata = $urandom;
      wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      trap = ($urandom_range(0, 79) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if (n % 200 == 199) begin
        for (int i = 0; i < NWP; i++) wpmode[i] = 2'($urandom_range(0, 3));
        rst = 1;
      end
      step();
    end
    rst = 0;
    idle_bus();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
